// File: rtl/match_ctl_if.sv
// Signal bundle between match_ctl and the screen FSM / ball logic.
// Names mirror the match controller's external signal names.
interface match_ctl_if #(
    parameter int SCORE_W = 4
);
    logic               enable;
    logic               vsync_in;
    logic               mouse_left;
    logic               difficulty;
    logic               miss_left;
    logic               miss_right;
    logic               ball_run;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               game_over;
    logic               winner;
    logic [2:0]         state_out;

    modport master (
        output enable, vsync_in, mouse_left, difficulty,
        output miss_left, miss_right,
        input  ball_run, ball_reset, serve_dir,
        input  score_left, score_right,
        input  game_over, winner, state_out
    );

    modport slave (
        input  enable, vsync_in, mouse_left, difficulty,
        input  miss_left, miss_right,
        output ball_run, ball_reset, serve_dir,
        output score_left, score_right,
        output game_over, winner, state_out
    );
endinterface

// File: rtl/match_ctl.sv
// Pong match sequencer: serve countdown, rally, scoring, game-over hold.
// Optional MATCH_PAUSE_EN adds a click-toggled PAUSED state during PLAY.
module match_ctl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int SCORE_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    match_ctl_if.slave  bus
);
    localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ?
                             SERVE_FRAMES : OVER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SERVE_LD  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] SERVE_LDH = CNT_W'(SERVE_FRAMES >> 1);
    localparam logic [CNT_W-1:0] OVER_LD   = CNT_W'(OVER_FRAMES);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [SCORE_W-1:0] score_l, score_r, nxt_sl, nxt_sr;
    logic               dir, nxt_dir;
    logic               win, nxt_win;
    logic               rstp, nxt_rstp;
    logic               run, over;
    logic               vsync_d, mouse_d;
    logic               tick, click;
    logic [CNT_W-1:0]   serve_load;

    assign tick       = bus.vsync_in & ~vsync_d;
    assign click      = bus.mouse_left & ~mouse_d;
    assign serve_load = bus.difficulty ? SERVE_LDH : SERVE_LD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            score_l <= '0;
            score_r <= '0;
            dir     <= 1'b0;
            win     <= 1'b0;
            rstp    <= 1'b0;
            run     <= 1'b0;
            over    <= 1'b0;
            vsync_d <= 1'b0;
            mouse_d <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            score_l <= nxt_sl;
            score_r <= nxt_sr;
            dir     <= nxt_dir;
            win     <= nxt_win;
            rstp    <= nxt_rstp;
            run     <= (nxt_state == PLAY);
            over    <= (nxt_state == GAME_OVER);
            vsync_d <= bus.vsync_in;
            mouse_d <= bus.mouse_left;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_sl    = score_l;
        nxt_sr    = score_r;
        nxt_dir   = dir;
        nxt_win   = win;
        nxt_rstp  = 1'b0;
        if (!bus.enable) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_sl    = '0;
            nxt_sr    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    nxt_sl = '0;
                    nxt_sr = '0;
                    if (click) begin
                        nxt_state = SERVE;
                        nxt_rstp  = 1'b1;
                        nxt_cnt   = serve_load;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (cnt == '0) nxt_state = PLAY;
                        else           nxt_cnt   = cnt - 1'b1;
                    end
                end
                PLAY: begin
                    // a double miss is a dead ball: re-serve, nobody scores
                    if (bus.miss_left && bus.miss_right) begin
                        nxt_state = POINT;
                    end else if (bus.miss_left) begin
                        nxt_sr    = score_r + 1'b1;
                        nxt_dir   = 1'b0;
                        nxt_state = POINT;
                    end else if (bus.miss_right) begin
                        nxt_sl    = score_l + 1'b1;
                        nxt_dir   = 1'b1;
                        nxt_state = POINT;
                    end
`ifdef MATCH_PAUSE_EN
                    else if (click) begin
                        nxt_state = PAUSED;
                    end
`endif
                end
                POINT: begin
                    if (score_l == WIN || score_r == WIN) begin
                        nxt_state = GAME_OVER;
                        nxt_win   = (score_r == WIN);
                        nxt_cnt   = OVER_LD;
                    end else begin
                        nxt_state = SERVE;
                        nxt_rstp  = 1'b1;
                        nxt_cnt   = serve_load;
                    end
                end
                GAME_OVER: begin
                    if (click || (tick && cnt == '0)) begin
                        nxt_state = IDLE;
                        nxt_sl    = '0;
                        nxt_sr    = '0;
                    end else if (tick) begin
                        nxt_cnt = cnt - 1'b1;
                    end
                end
`ifdef MATCH_PAUSE_EN
                PAUSED: begin
                    if (click) nxt_state = PLAY;
                end
`endif
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign bus.ball_run    = run;
    assign bus.ball_reset  = rstp;
    assign bus.serve_dir   = dir;
    assign bus.score_left  = score_l;
    assign bus.score_right = score_r;
    assign bus.game_over   = over;
    assign bus.winner      = win;
    assign bus.state_out   = state;
endmodule

// File: tb/tb_match_ctl.sv
// Scoreboard bench for match_ctl: stimulus queues expected state events,
// a negedge monitor pops one per observed state change and compares.
module tb_match_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    match_ctl_if #(.SCORE_W(4)) bus ();

    match_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] st;
        logic       run;
        logic       rstp;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic       win;
        int         ticks;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   tick_cnt = 0;
    int   ev_n = 0;

    logic [3:0] m_sl = '0;
    logic [3:0] m_sr = '0;
    logic       m_dir = 1'b0;
    logic       m_win = 1'b0;

    logic       first = 1'b1;
    logic [2:0] prev_st = '0;

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (first || bus.state_out != prev_st) begin
            ev_n++;
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event%0d: st=%0d, none expected",
                         ev_n, bus.state_out);
            end else begin
                e  = q.pop_front();
                ok = (bus.state_out === e.st) && (bus.ball_run === e.run) &&
                     (bus.ball_reset === e.rstp) &&
                     (bus.serve_dir === e.dir) &&
                     (bus.score_left === e.sl) &&
                     (bus.score_right === e.sr) &&
                     (bus.game_over === e.go) && (bus.winner === e.win) &&
                     (e.ticks < 0 || tick_cnt == e.ticks);
                if (ok) passed++;
                else $display({"FAIL event%0d: got st=%0d run=%b rst=%b ",
                    "dir=%b sl=%0d sr=%0d go=%b win=%b ticks=%0d; ",
                    "expected st=%0d run=%b rst=%b dir=%b sl=%0d sr=%0d ",
                    "go=%b win=%b ticks=%0d"}, ev_n,
                    bus.state_out, bus.ball_run, bus.ball_reset,
                    bus.serve_dir, bus.score_left, bus.score_right,
                    bus.game_over, bus.winner, tick_cnt,
                    e.st, e.run, e.rstp, e.dir, e.sl, e.sr, e.go, e.win,
                    e.ticks);
            end
            tick_cnt = 0;
        end else if (bus.ball_reset) begin
            total++;
            $display("FAIL spurious_ball_reset: got 1 in st=%0d, expected 0",
                     bus.state_out);
        end
        prev_st = bus.state_out;
        first   = 1'b0;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [2:0] st, input logic rp,
                             input int ticks);
        exp_t e;
        e.st    = st;
        e.run   = (st == 3'd2);
        e.rstp  = rp;
        e.dir   = m_dir;
        e.sl    = m_sl;
        e.sr    = m_sr;
        e.go    = (st == 3'd4);
        e.win   = m_win;
        e.ticks = ticks;
        q.push_back(e);
    endtask

    task automatic click();
        bus.mouse_left = 1'b1;
        cyc(1);
        bus.mouse_left = 1'b0;
        cyc(1);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            bus.vsync_in = 1'b1;
            tick_cnt++;
            cyc(1);
            bus.vsync_in = 1'b0;
            cyc(1);
        end
    endtask

    task automatic start_play(input int n);
        cyc(3);
        expect_ev(3'd2, 1'b0, n);
        tick_n(n);
        cyc(2);
    endtask

    task automatic point(input logic ml, input logic mr);
        if (ml && !mr) begin
            m_sr++;
            m_dir = 1'b0;
        end else if (mr && !ml) begin
            m_sl++;
            m_dir = 1'b1;
        end
        expect_ev(3'd3, 1'b0, -1);
        if (m_sl == 4'd5 || m_sr == 4'd5) begin
            m_win = (m_sr == 4'd5);
            expect_ev(3'd4, 1'b0, -1);
        end else begin
            expect_ev(3'd1, 1'b1, -1);
        end
        bus.miss_left  = ml;
        bus.miss_right = mr;
        cyc(1);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        cyc(3);
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.vsync_in   = 1'b0;
        bus.mouse_left = 1'b0;
        bus.difficulty = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        expect_ev(3'd0, 1'b0, -1);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        bus.enable = 1'b1;
        cyc(1);

        // match A: full-length serve, then left wins, timeout exit
        expect_ev(3'd1, 1'b1, -1);
        click();
        start_play(61);
`ifdef MATCH_PAUSE_EN
        expect_ev(3'd5, 1'b0, -1);
        click();
        bus.miss_left = 1'b1;
        cyc(1);
        bus.miss_left = 1'b0;
        cyc(1);
        expect_ev(3'd2, 1'b0, -1);
        click();
        cyc(2);
`else
        click();
        cyc(2);
`endif
        bus.difficulty = 1'b1;
        point(1'b0, 1'b1);
        start_play(31);
        point(1'b1, 1'b1);
        start_play(31);
        repeat (4) begin
            point(1'b0, 1'b1);
            if (m_sl != 4'd5) start_play(31);
        end
        cyc(3);
        m_sl = '0;
        m_sr = '0;
        expect_ev(3'd0, 1'b0, 181);
        tick_n(181);
        cyc(2);

        // match B: right wins, click exit
        expect_ev(3'd1, 1'b1, -1);
        click();
        start_play(31);
        repeat (5) begin
            point(1'b1, 1'b0);
            if (m_sr != 4'd5) start_play(31);
        end
        m_sl = '0;
        m_sr = '0;
        expect_ev(3'd0, 1'b0, -1);
        click();
        cyc(2);

        // match C: enable dropped during serve
        expect_ev(3'd1, 1'b1, -1);
        click();
        tick_n(5);
        expect_ev(3'd0, 1'b0, -1);
        bus.enable = 1'b0;
        cyc(2);
        bus.enable = 1'b1;
        cyc(2);

        // match D: miss in SERVE ignored, reach 2:1, async reset in PLAY
        expect_ev(3'd1, 1'b1, -1);
        click();
        bus.miss_right = 1'b1;
        cyc(1);
        bus.miss_right = 1'b0;
        start_play(31);
        point(1'b0, 1'b1);
        start_play(31);
        point(1'b0, 1'b1);
        start_play(31);
        point(1'b1, 1'b0);
        start_play(31);
        m_sl  = '0;
        m_sr  = '0;
        m_dir = 1'b0;
        m_win = 1'b0;
        expect_ev(3'd0, 1'b0, -1);
        #1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);

        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL leftover_events: got %0d pending, expected 0",
                      q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
